// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial N-bit adder sequencer. It feeds one operand bit
//               pair per clock, LSB first, through a single full_adder cell.
//               The optional signed-overflow output is enabled by defining
//               SERIAL_ADD_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// One-bit full adder cell. The serial sequencer below reuses it for every bit.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic         ovf,
`endif
    output logic         cout
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [N-1:0]  sha;
    logic [N-1:0]  shb;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sum_q;
    logic          cout_q;
`ifdef SERIAL_ADD_OVF_EN
    logic          ovf_q;
`endif

    logic          fa_s;
    logic          fa_co;
    logic          accept;
    logic          last_bit;

    full_adder u_fa (
        .a  (sha[0]),
        .b  (shb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Start is only honoured when no addition is in flight.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sha    <= '0;
            shb    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if (accept) begin
            sha    <= a;
            shb    <= b;
            carry  <= cin;
            cnt    <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if (state == RUN) begin
            carry <= fa_co;
            sum_q <= {fa_s, sum_q[N-1:1]};
            sha   <= sha >> 1;
            shb   <= shb >> 1;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                cout_q <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                // Signed overflow: carry into the MSB differs from carry out of it.
                ovf_q  <= carry ^ fa_co;
`endif
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

`default_nettype wire
